prng_bank: RTL and testbench

Parametrised multi-source pseudo-random number generator. It runs `NUM_GEN` cellular-automaton and LFSR generators in parallel and selects one per cycle using XOR-of-tap-bit priority logic. It adds runtime reseeding, a warm-up phase, zero-state lockup recovery and a ready/valid output stream. It sits between the randomness sources and any consumer that needs one N-bit random word per handshake.

---
 rtl/prng_pkg.sv | 28 ++
 rtl/prng_bank_if.sv | 26 ++
 rtl/prng_cell.sv | 60 ++++++
 rtl/prng_bank.sv | 121 ++++++++++++
 tb/tb_prng_bank.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/prng_pkg.sv
// Shared constants, enums and seed helpers for the PRNG bank.
package prng_pkg;

  localparam logic [31:0] DEFAULT_SEED = 32'h14784518;
  localparam logic [31:0] GOLDEN       = 32'h9E3779B9;

  typedef enum logic [1:0] {
    PRNG_LFSR = 2'd0,
    PRNG_R30  = 2'd1,
    PRNG_R149 = 2'd2
  } prng_mode_e;

  typedef enum logic {
    WARM = 1'b0,
    RUN  = 1'b1
  } prng_state_e;

  // Reset seed of generator g, before truncation to the word width.
  function automatic logic [31:0] gen_seed(input int unsigned g);
    return DEFAULT_SEED ^ (32'(g) * GOLDEN);
  endfunction

  // Generators cycle through LFSR, Rule 30, Rule 149.
  function automatic prng_mode_e gen_mode(input int unsigned g);
    return prng_mode_e'(2'(g % 3));
  endfunction

endpackage

// File: rtl/prng_bank_if.sv
// Seed-write and random-word stream bundle; master is the consumer side, slave is the bank.
interface prng_bank_if #(
  parameter int unsigned N       = 32,
  parameter int unsigned NUM_GEN = 6
);
  localparam int unsigned IW = $clog2(NUM_GEN);

  logic          seed_valid;
  logic          seed_ready;
  logic [IW-1:0] seed_idx;
  logic [N-1:0]  seed_data;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_data;
  logic          lockup_fix;

  modport master (
    output seed_valid, seed_idx, seed_data, out_ready,
    input  seed_ready, out_valid, out_data, lockup_fix
  );

  modport slave (
    input  seed_valid, seed_idx, seed_data, out_ready,
    output seed_ready, out_valid, out_data, lockup_fix
  );
endinterface

// File: rtl/prng_cell.sv
// One generator: LFSR, Rule 30 or Rule 149 automaton with load and zero-state recovery.
module prng_cell
  import prng_pkg::*;
#(
  parameter int unsigned N          = 32,
  parameter prng_mode_e  MODE       = PRNG_LFSR,
  parameter logic [N-1:0] TAPS      = '1,
  parameter logic [N-1:0] RESET_SEED = '1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         step,
  input  logic         load,
  input  logic [N-1:0] load_data,
  output logic [N-1:0] state,
  output logic         zero_fix
);

  // All-zero is a fixed point for LFSR and Rule 30 only; Rule 149 leaves it by itself.
  localparam logic ZERO_STUCK = (MODE != PRNG_R149);

  logic [N+1:0] pad_c;
  logic [N-1:0] next_c;

  assign pad_c = {1'b0, state, 1'b0};

  // One update step; pad_c supplies the 0 boundary cells (left = i+2, centre = i+1, right = i).
  always_comb begin
    next_c = state;
    if (MODE == PRNG_LFSR) begin
      next_c = {state[N-2:0], ^(state & TAPS)};
    end else begin
      for (int i = 0; i < N; i++) begin
        if (MODE == PRNG_R30)
          next_c[i] = pad_c[i+2] ^ (pad_c[i+1] | pad_c[i]);
        else
          next_c[i] = ~((pad_c[i+2] & pad_c[i+1]) ^ pad_c[i]);
      end
    end
  end

  // State register: load beats lockup recovery, which beats stepping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= RESET_SEED;
      zero_fix <= 1'b0;
    end else begin
      zero_fix <= 1'b0;
      if (load) begin
        state <= load_data;
      end else if (ZERO_STUCK && (state == '0)) begin
        state    <= RESET_SEED;
        zero_fix <= 1'b1;
      end else if (step) begin
        state <= next_c;
      end
    end
  end

endmodule

// File: rtl/prng_bank.sv
// Bank of parallel generators with tap-bit priority selection, warm-up and ready/valid output.
module prng_bank
  import prng_pkg::*;
#(
  parameter int unsigned N         = 32,
  parameter int unsigned NUM_GEN   = 6,
  parameter int unsigned WARMUP    = 8,
  parameter logic [63:0] LFSR_TAPS = 64'h80200003
) (
  input logic        clk,
  input logic        reset_n,
  prng_bank_if.slave bus
);

  localparam int unsigned  CW        = 8;
  localparam logic [CW-1:0] WARM_LAST = CW'(WARMUP - 1);

  logic [N-1:0]       gen     [NUM_GEN];
  logic [N-1:0]       gen_nxt [NUM_GEN];
  logic [NUM_GEN-1:0] sel_c;
  logic [NUM_GEN-1:0] zero_fix;
  logic [N-1:0]       cand_c;
  logic               seed_hs_c;
  logic               step_c;
  logic               load_out_c;

  prng_state_e   state, state_d;
  logic [CW-1:0] cnt, cnt_d;

  // Accepted seed write that targets an existing generator.
  assign seed_hs_c = bus.seed_valid && bus.seed_ready && (32'(bus.seed_idx) < NUM_GEN);

  for (genvar g = 0; g < NUM_GEN; g++) begin : g_gen
    localparam logic [N-1:0] SEED_G = N'(gen_seed(g));
    localparam int unsigned  NXT    = (g + 1) % NUM_GEN;
    localparam int unsigned  BA     = (7 * g + 3) % N;
    localparam int unsigned  BB     = (11 * g + 5) % N;

    prng_cell #(
      .N          (N),
      .MODE       (gen_mode(g)),
      .TAPS       (N'(LFSR_TAPS)),
      .RESET_SEED (SEED_G)
    ) u_cell (
      .clk       (clk),
      .reset_n   (reset_n),
      .step      (step_c),
      .load      (seed_hs_c && (32'(bus.seed_idx) == 32'(g))),
      .load_data ((bus.seed_data == '0) ? SEED_G : bus.seed_data),
      .state     (gen[g]),
      .zero_fix  (zero_fix[g])
    );

    assign sel_c[g]   = gen[g][BA] ^ gen[NXT][BB];
    assign gen_nxt[g] = gen[NXT];
  end

  // Lowest set select bit k picks gen[k+1]; none set falls back to the last generator.
  always_comb begin
    cand_c = gen[NUM_GEN-1];
    for (int k = NUM_GEN - 1; k >= 0; k--) begin
      if (sel_c[k]) cand_c = gen_nxt[k];
    end
  end

  // FSM state and warm-up counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= WARM;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  // Next state, generator step enable and output-load strobe; a seed write restarts warm-up.
  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    step_c     = 1'b0;
    load_out_c = 1'b0;
    case (state)
      WARM: begin
        step_c = 1'b1;
        if (cnt == WARM_LAST) state_d = RUN;
        else                  cnt_d   = cnt + CW'(1);
      end
      RUN: begin
        step_c     = !bus.out_valid || bus.out_ready;
        load_out_c = step_c;
      end
      default: state_d = WARM;
    endcase
    if (seed_hs_c) begin
      state_d    = WARM;
      cnt_d      = '0;
      load_out_c = 1'b0;
    end
  end

  // Output word register and seed-port readiness.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.out_valid  <= 1'b0;
      bus.out_data   <= '0;
      bus.seed_ready <= 1'b0;
    end else begin
      bus.seed_ready <= 1'b1;
      if (seed_hs_c) begin
        bus.out_valid <= 1'b0;
      end else if (load_out_c) begin
        bus.out_valid <= 1'b1;
        bus.out_data  <= cand_c;
      end
    end
  end

  assign bus.lockup_fix = |zero_fix;

endmodule

// File: tb/tb_prng_bank.sv
// Testbench for prng_bank: reference model feeding an expected-word queue, plus standalone cell checks.
module tb_prng_bank;
  import prng_pkg::*;

  localparam int unsigned N  = 32;
  localparam int unsigned NG = 6;
  localparam int unsigned WU = 8;
  localparam logic [31:0] TAPS = 32'h80200003;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  prng_bank_if #(.N(N), .NUM_GEN(NG)) bus ();

  prng_bank #(.N(N), .NUM_GEN(NG), .WARMUP(WU), .LFSR_TAPS(64'h80200003)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Small 8-bit cells for the single-step checks.
  logic       c_step, c_load;
  logic [7:0] d_l, d_30, d_149;
  logic [7:0] st_l, st_30, st_149;
  logic       zf_l, zf_30, zf_149;

  prng_cell #(.N(8), .MODE(PRNG_LFSR), .TAPS(8'hB8), .RESET_SEED(8'h5A)) u_cl (
    .clk(clk), .reset_n(reset_n), .step(c_step), .load(c_load), .load_data(d_l),
    .state(st_l), .zero_fix(zf_l));
  prng_cell #(.N(8), .MODE(PRNG_R30), .TAPS(8'hFF), .RESET_SEED(8'hC3)) u_c30 (
    .clk(clk), .reset_n(reset_n), .step(c_step), .load(c_load), .load_data(d_30),
    .state(st_30), .zero_fix(zf_30));
  prng_cell #(.N(8), .MODE(PRNG_R149), .TAPS(8'hFF), .RESET_SEED(8'h3C)) u_c149 (
    .clk(clk), .reset_n(reset_n), .step(c_step), .load(c_load), .load_data(d_149),
    .state(st_149), .zero_fix(zf_149));

  int checks = 0;
  int errors = 0;
  logic [31:0] sb [$];
  logic [31:0] mg [NG];

  // Reference model of the bank generators.
  function automatic logic [31:0] m_seed(input int g);
    return 32'h14784518 ^ (32'(g) * 32'h9E3779B9);
  endfunction

  function automatic logic [31:0] m_next(input int mode, input logic [31:0] s);
    if (mode == 0) return {s[30:0], ^(s & TAPS)};
    if (mode == 1) return (s >> 1) ^ (s | (s << 1));
    return ~(((s >> 1) & s) ^ (s << 1));
  endfunction

  function automatic void m_step_one(input int g);
    if (mg[g] == 32'h0 && (g % 3) != 2) mg[g] = m_seed(g);
    else mg[g] = m_next(g % 3, mg[g]);
  endfunction

  function automatic void m_step_all();
    for (int g = 0; g < NG; g++) m_step_one(g);
  endfunction

  function automatic logic [31:0] m_word();
    logic [31:0] w;
    w = mg[NG-1];
    for (int k = NG - 1; k >= 0; k--)
      if (mg[k][(7*k+3)%32] ^ mg[(k+1)%NG][(11*k+5)%32]) w = mg[(k+1)%NG];
    m_step_all();
    return w;
  endfunction

  function automatic void m_reset();
    for (int g = 0; g < NG; g++) mg[g] = m_seed(g);
    for (int i = 0; i < int'(WU); i++) m_step_all();
    sb.delete();
    sb.push_back(m_word());
  endfunction

  task automatic test_reset();
    reset_n = 1'b0;
    bus.seed_valid = 1'b0; bus.seed_idx = '0; bus.seed_data = '0; bus.out_ready = 1'b0;
    c_step = 1'b0; c_load = 1'b0; d_l = '0; d_30 = '0; d_149 = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.out_valid, bus.seed_ready, bus.lockup_fix} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got v/sr/lf=%b required 000", {bus.out_valid, bus.seed_ready, bus.lockup_fix});
    end
    checks++;
    if (bus.out_data !== 32'h0) begin
      errors++; $display("FAIL reset_data: got %h required 0", bus.out_data);
    end
  endtask

  task automatic test_release_stream();
    logic [31:0] seen [$];
    int first;
    logic dup;
    m_reset();
    bus.out_ready = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    checks++;
    if (bus.seed_ready !== 1'b0) begin
      errors++; $display("FAIL seed_ready_pre_edge: got %b required 0", bus.seed_ready);
    end
    first = 0;
    for (int e = 1; e <= 20; e++) begin
      @(posedge clk); #1;
      if (e == 1) begin
        checks++;
        if (bus.seed_ready !== 1'b1) begin
          errors++; $display("FAIL seed_ready_edge1: got %b required 1", bus.seed_ready);
        end
      end
      if (bus.out_valid === 1'b1) begin first = e; break; end
    end
    checks++;
    if (first != int'(WU) + 1) begin
      errors++; $display("FAIL first_valid_edge: got %0d required %0d", first, WU + 1);
    end
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1 || sb.size() == 0 || bus.out_data !== sb[0]) begin
        errors++; $display("FAIL stream[%0d]: valid=%b data=%h required %h", c, bus.out_valid, bus.out_data, (sb.size() != 0) ? sb[0] : 32'hx);
      end
      dup = 1'b0;
      foreach (seen[j]) if (seen[j] === bus.out_data) dup = 1'b1;
      checks++;
      if (dup) begin
        errors++; $display("FAIL no_repeat[%0d]: word %h seen before, required fresh", c, bus.out_data);
      end
      seen.push_back(bus.out_data);
      if (sb.size() != 0) void'(sb.pop_front());
      sb.push_back(m_word());
      @(posedge clk); #1;
    end
  endtask

  task automatic test_stall();
    bus.out_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== sb[0]) begin
        errors++; $display("FAIL stall_hold[%0d]: valid=%b data=%h required 1/%h", c, bus.out_valid, bus.out_data, sb[0]);
      end
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1 || sb.size() == 0 || bus.out_data !== sb[0]) begin
        errors++; $display("FAIL stall_resume[%0d]: valid=%b data=%h required %h", c, bus.out_valid, bus.out_data, (sb.size() != 0) ? sb[0] : 32'hx);
      end
      if (sb.size() != 0) void'(sb.pop_front());
      sb.push_back(m_word());
      @(posedge clk); #1;
    end
  endtask

  task automatic test_seed_zero();
    int lows;
    bus.seed_valid = 1'b1; bus.seed_idx = 3'd0; bus.seed_data = 32'h0;
    @(negedge clk);
    checks++;
    if (bus.seed_ready !== 1'b1) begin
      errors++; $display("FAIL seed0_ready: got %b required 1", bus.seed_ready);
    end
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== sb[0]) begin
      errors++; $display("FAIL seed0_last_word: valid=%b data=%h required 1/%h", bus.out_valid, bus.out_data, sb[0]);
    end
    void'(sb.pop_front());
    for (int g = 1; g < NG; g++) m_step_one(g);
    mg[0] = 32'h14784518;
    for (int i = 0; i < int'(WU); i++) m_step_all();
    sb.push_back(m_word());
    @(posedge clk); #1;
    bus.seed_valid = 1'b0;
    lows = 0;
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (bus.lockup_fix !== 1'b0) begin
        errors++; $display("FAIL seed0_lockup[%0d]: got %b required 0", i, bus.lockup_fix);
      end
      if (bus.out_valid === 1'b1) break;
      lows++;
      @(posedge clk); #1;
    end
    checks++;
    if (lows != int'(WU) + 1) begin
      errors++; $display("FAIL seed0_gap: got %0d low cycles required %0d", lows, WU + 1);
    end
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1 || sb.size() == 0 || bus.out_data !== sb[0] || bus.lockup_fix !== 1'b0) begin
        errors++; $display("FAIL seed0_stream[%0d]: valid=%b data=%h lf=%b required 1/%h/0", c, bus.out_valid, bus.out_data, bus.lockup_fix, (sb.size() != 0) ? sb[0] : 32'hx);
      end
      if (sb.size() != 0) void'(sb.pop_front());
      sb.push_back(m_word());
      @(posedge clk); #1;
    end
  endtask

  task automatic test_seed_oob();
    bus.seed_valid = 1'b1; bus.seed_idx = 3'd7; bus.seed_data = 32'hDEADBEEF;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c == 0) begin
        checks++;
        if (bus.seed_ready !== 1'b1) begin
          errors++; $display("FAIL oob_ready: got %b required 1", bus.seed_ready);
        end
      end
      checks++;
      if (bus.out_valid !== 1'b1 || sb.size() == 0 || bus.out_data !== sb[0]) begin
        errors++; $display("FAIL oob_stream[%0d]: valid=%b data=%h required 1/%h", c, bus.out_valid, bus.out_data, (sb.size() != 0) ? sb[0] : 32'hx);
      end
      if (sb.size() != 0) void'(sb.pop_front());
      sb.push_back(m_word());
      @(posedge clk); #1;
      bus.seed_valid = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    int first;
    reset_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 32'h0 || bus.seed_ready !== 1'b0) begin
      errors++; $display("FAIL mid_reset: valid=%b data=%h sr=%b required 0/0/0", bus.out_valid, bus.out_data, bus.seed_ready);
    end
    m_reset();
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    first = 0;
    for (int e = 1; e <= 20; e++) begin
      @(posedge clk); #1;
      if (bus.out_valid === 1'b1) begin first = e; break; end
    end
    checks++;
    if (first != int'(WU) + 1) begin
      errors++; $display("FAIL mid_first_valid: got %0d required %0d", first, WU + 1);
    end
    for (int c = 0; c < 32; c++) begin
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1 || sb.size() == 0 || bus.out_data !== sb[0]) begin
        errors++; $display("FAIL mid_stream[%0d]: valid=%b data=%h required %h", c, bus.out_valid, bus.out_data, (sb.size() != 0) ? sb[0] : 32'hx);
      end
      if (sb.size() != 0) void'(sb.pop_front());
      sb.push_back(m_word());
      @(posedge clk); #1;
    end
  endtask

  task automatic test_cells();
    c_load = 1'b1; d_l = 8'h01; d_30 = 8'h10; d_149 = 8'h00;
    @(posedge clk); #1;
    c_load = 1'b0; c_step = 1'b1;
    checks++;
    if ({st_l, st_30, st_149} !== {8'h01, 8'h10, 8'h00}) begin
      errors++; $display("FAIL cell_load: got %h %h %h required 01 10 00", st_l, st_30, st_149);
    end
    @(posedge clk); #1;
    c_step = 1'b0;
    checks++;
    if ({st_l, st_30, st_149} !== {8'h02, 8'h38, 8'hFF}) begin
      errors++; $display("FAIL cell_step: got %h %h %h required 02 38 FF", st_l, st_30, st_149);
    end
    checks++;
    if (zf_149 !== 1'b0) begin
      errors++; $display("FAIL cell_r149_fix: got %b required 0", zf_149);
    end
    c_load = 1'b1; d_l = 8'h00; d_30 = 8'h00; d_149 = 8'h00;
    @(posedge clk); #1;
    c_load = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({st_l, st_30, st_149, zf_l, zf_30, zf_149} !== {8'h5A, 8'hC3, 8'h00, 3'b110}) begin
      errors++; $display("FAIL cell_lockup: got %h %h %h zf=%b%b%b required 5A C3 00 zf=110", st_l, st_30, st_149, zf_l, zf_30, zf_149);
    end
    @(posedge clk); #1;
    checks++;
    if ({zf_l, zf_30, zf_149} !== 3'b000) begin
      errors++; $display("FAIL cell_fix_pulse: got zf=%b%b%b required 000", zf_l, zf_30, zf_149);
    end
  endtask

  initial begin
    test_reset();
    test_release_stream();
    test_stall();
    test_seed_zero();
    test_seed_oob();
    test_reset_mid();
    test_cells();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
